// File: rtl/x_delay_nch_pkg.sv
// Shared constants for the multi-channel delay line: default sizes, the derived
// stage count, and the slice macros used to address one channel of a packed bus.
`ifndef X_DELAY_NCH_PKG_MACROS
`define X_DELAY_NCH_PKG_MACROS
`define X_DLY_D(c, w)     ((c) * (w)) +: (w)
`define X_DLY_DELAY(c, m) ((c) * (m)) +: (m)
`define X_DLY_Q(c, w)     ((c) * (w)) +: (w)
`endif

package x_delay_nch_pkg;

  localparam int DEF_NCH   = 32'sd4;
  localparam int DEF_WIDTH = 32'sd8;
  localparam int DEF_MXDLY = 32'sd4;
  localparam int DEF_OREG  = 32'sd0;

  // Number of taps plus one: a MXDLY-bit delay addresses stages 1..2^MXDLY-1.
  function automatic int calc_mxsr(input int mxdly);
    return int'(32'd1 << mxdly);
  endfunction

endpackage

// File: rtl/x_delay_ch.sv
// One channel of the delay line: WIDTH-bit shift stages with per-stage valid bits,
// a delay-selected tap (tap 0 is the live input) and an optional output register.
module x_delay_ch
  import x_delay_nch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MXDLY = DEF_MXDLY,
  parameter int OREG  = DEF_OREG
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic [MXDLY-1:0] delay,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  localparam int MXSR = calc_mxsr(MXDLY);

  logic [WIDTH-1:0] sr_r [1:MXSR-1];
  logic [MXSR-1:1]  vld_r;
  logic [WIDTH-1:0] sel_word_s;
  logic             sel_vld_s;

  // Stage shift: reset clears all, ce advances data, flush invalidates every stage.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 1; i < MXSR; i++) begin
        sr_r[i] <= '0;
      end
      vld_r <= '0;
    end else if (ce) begin
      sr_r[1]  <= d;
      vld_r[1] <= ~flush;
      for (int i = 2; i < MXSR; i++) begin
        sr_r[i]  <= sr_r[i-1];
        vld_r[i] <= vld_r[i-1] & ~flush;
      end
    end else if (flush) begin
      vld_r <= '0;
    end
  end

  // Tap select: a delay change takes effect at once, using whatever the new tap holds.
  always_comb begin
    sel_word_s = d;
    sel_vld_s  = reset_n;
    if (delay == {MXDLY{1'b0}}) begin
      sel_word_s = d;
      sel_vld_s  = reset_n;
    end else begin
      sel_word_s = sr_r[delay];
      sel_vld_s  = vld_r[delay];
    end
  end

  if (OREG != 0) begin : g_oreg
    // Output register: samples the selection every clock, independent of ce.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        q       <= '0;
        q_valid <= 1'b0;
      end else begin
        q       <= sel_word_s;
        q_valid <= sel_vld_s;
      end
    end
  end else begin : g_comb
    assign q       = sel_word_s;
    assign q_valid = sel_vld_s & reset_n;
  end

endmodule

// File: rtl/x_delay_nch.sv
// Multi-channel programmable delay line: NCH independent channels sharing clock,
// reset, shift-enable and flush, each with its own delay setting.
module x_delay_nch
  import x_delay_nch_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int MXDLY = DEF_MXDLY,
  parameter int OREG  = DEF_OREG
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 flush,
  input  logic [NCH*WIDTH-1:0] d,
  input  logic [NCH*MXDLY-1:0] delay,
  output logic [NCH*WIDTH-1:0] q,
  output logic [NCH-1:0]       q_valid
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    x_delay_ch #(
      .WIDTH (WIDTH),
      .MXDLY (MXDLY),
      .OREG  (OREG)
    ) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
      .ce      (ce),
      .flush   (flush),
      .d       (d[`X_DLY_D(c, WIDTH)]),
      .delay   (delay[`X_DLY_DELAY(c, MXDLY)]),
      .q       (q[`X_DLY_Q(c, WIDTH)]),
      .q_valid (q_valid[c])
    );
  end

endmodule

// File: tb/tb_x_delay_nch.sv
// Directed bench for x_delay_nch: drives a counting pattern into an OREG=0 and an
// OREG=1 instance side by side and checks both against arithmetic expectations.
module tb_x_delay_nch;

  localparam int NCH   = 4;
  localparam int WIDTH = 8;
  localparam int MXDLY = 4;

  logic                 clock;
  logic                 reset_n;
  logic                 ce;
  logic                 flush;
  logic [NCH*WIDTH-1:0] d;
  logic [NCH*MXDLY-1:0] delay;
  logic [NCH*WIDTH-1:0] q0, q1;
  logic [NCH-1:0]       qv0, qv1;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  int seq      = 0;   // index of the word currently presented on d
  int base     = 0;   // first word index captured since the last reset
  int fill     = 0;   // ce edges since the last reset or flush (saturating)
  logic [7:0] exp1_q [NCH];
  logic       exp1_v [NCH];

  x_delay_nch #(.NCH(NCH), .WIDTH(WIDTH), .MXDLY(MXDLY), .OREG(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .ce(ce), .flush(flush),
    .d(d), .delay(delay), .q(q0), .q_valid(qv0));

  x_delay_nch #(.NCH(NCH), .WIDTH(WIDTH), .MXDLY(MXDLY), .OREG(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .ce(ce), .flush(flush),
    .d(d), .delay(delay), .q(q1), .q_valid(qv1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Word for channel c at sequence index idx; ch0 counts 0x01, 0x02, ...
  function automatic logic [7:0] fw(input int c, input int idx);
    return 8'(idx + 1 + 64 * c);
  endfunction

  task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ch%0d edge%0d observed=%0h expected=%0h", tag, c, edges, obs, exp);
    end
  endtask

  task automatic step(input logic ce_i, input logic flush_i);
    logic [7:0] eq [NCH];
    logic       ev [NCH];
    int         k;
    ce    = ce_i;
    flush = flush_i;
    for (int c = 0; c < NCH; c++) d[c*WIDTH +: WIDTH] = fw(c, seq);
    #1;
    for (int c = 0; c < NCH; c++) begin
      k = int'(delay[c*MXDLY +: MXDLY]);
      if (k == 0) begin
        eq[c] = fw(c, seq);
        ev[c] = reset_n;
      end else begin
        eq[c] = (seq - k >= base) ? fw(c, seq - k) : 8'h00;
        ev[c] = reset_n && (fill >= k);
      end
      if (edges > 0) begin
        chk("q_comb",  c, q0[c*WIDTH +: WIDTH], eq[c]);
        chk("qv_comb", c, 8'(qv0[c]), 8'(ev[c]));
        chk("q_oreg",  c, q1[c*WIDTH +: WIDTH], exp1_q[c]);
        chk("qv_oreg", c, 8'(qv1[c]), 8'(exp1_v[c]));
      end
    end
    @(posedge clock);
    edges++;
    if (!reset_n) begin
      base = seq;
      fill = 0;
      for (int c = 0; c < NCH; c++) begin
        exp1_q[c] = 8'h00;
        exp1_v[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        exp1_q[c] = eq[c];
        exp1_v[c] = ev[c];
      end
      if (ce_i) begin
        seq++;
        fill = flush_i ? 0 : ((fill < 16) ? fill + 1 : 16);
      end else if (flush_i) begin
        fill = 0;
      end
    end
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    ce      = 1'b0;
    flush   = 1'b0;
    d       = '0;
    delay   = {4'd15, 4'd7, 4'd3, 4'd5};
    #2;
    // Reset, then fill: ch0 at delay 5 shows 0x01 after the fifth edge.
    repeat (3) step(1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (20) step(1'b1, 1'b0);
    // Independent channels at 0/3/7/15.
    delay = {4'd15, 4'd7, 4'd3, 4'd0};
    repeat (20) step(1'b1, 1'b0);
    // ce gap mid-stream.
    repeat (4) step(1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0);
    // Flush with ce high at delay 4, then flush with ce low.
    delay = {4'd15, 4'd7, 4'd4, 4'd0};
    step(1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b0);
    // Live delay change 2 -> 9 before nine stages have refilled.
    delay = {4'd15, 4'd2, 4'd4, 4'd0};
    repeat (2) step(1'b1, 1'b0);
    delay = {4'd15, 4'd9, 4'd4, 4'd0};
    repeat (4) step(1'b1, 1'b0);
    // Reset has priority over ce and flush; outputs clear during reset.
    reset_n = 1'b0;
    repeat (2) step(1'b1, 1'b1);
    reset_n = 1'b1;
    repeat (6) step(1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/x_delay_nch.md
# x_delay_nch

Multi-channel, multi-bit programmable delay line. It is the parameterised successor to the single-bit delay stage. Each of NCH channels delays a WIDTH-bit word by 0 to 2^MXDLY−1 clocks under its own delay setting. Shift-enable, flush and per-stage valid tracking let downstream logic know when a delayed word is real data rather than post-reset or post-flush fill. It sits in trigger and readout paths wherever several parallel buses need independently trimmed latency alignment.

## Interface
- NCH, 4: number of independent channels
- WIDTH, 8: data bits per channel
- MXDLY, 4: delay-select bits per channel
- MXSR, 1<<MXDLY: delay stages + 1 (derived, not overridden)
- OREG, 0: 0 = combinational output mux; 1 = registered output (+1 clock)
- clock  input  1  single clock, all logic on posedge
- reset_n  input  1  reset: synchronous, active-low
- ce  input  1  shift enable, common to all channels
- flush  input  1  clears all valid bits, all channels
- d  input  NCH*WIDTH  input words; channel c at [c*WIDTH +: WIDTH]
- delay  input  NCH*MXDLY  per-channel delay; channel c at [c*MXDLY +: MXDLY]
- q  output  NCH*WIDTH  delayed words
- q_valid  output  NCH  per-channel: selected stage holds valid data

## Operation
- Per channel: stages sr[1..MXSR-1], each WIDTH data bits plus 1 valid bit vld.
- Clock edge with reset_n=0: all sr ← 0, all vld ← 0, output registers (OREG=1) ← 0. Reset has priority over ce and flush.
- Clock edge with ce=1, flush=0:
  - sr[1] ← d, vld[1] ← 1
  - sr[i] ← sr[i-1], vld[i] ← vld[i-1] for i = 2..MXSR-1
- Clock edge with ce=1, flush=1: data shifts exactly as above, but every vld (including vld[1]) ← 0.
- Clock edge with ce=0, flush=1: data holds, every vld ← 0.
- Clock edge with ce=0, flush=0: everything holds.
- Selection, channel c, k = delay[c]:
  - k=0: word = d[c], valid = reset_n.
  - k>0: word = sr[k], valid = vld[k].
- OREG=0: q and q_valid are that selection, combinational. q_valid is additionally forced 0 while reset_n=0.
- OREG=1: selection registered every clock, independent of ce. Reset value of q = 0 and q_valid = 0.
- Delay change:
  - Takes effect on the selection immediately (no re-sync).
  - The new tap's existing data and valid bits are used as-is.
  - A longer tap right after reset or flush therefore shows q_valid=0 until filled.
- Channels are fully independent except for shared ce, flush and reset.

## Timing
- With ce held high and OREG=0, a word presented on d before edge n appears on q after edge n+k−1 (visible from edge n+k−1 to n+k). k=0 is combinational pass-through.
- OREG=1 adds exactly one clock to every delay, including k=0.
- After reset release (first edge with reset_n=1) and ce held high, q_valid[c] rises k edges later. For k=0 it rises immediately (OREG=0) or after one edge (OREG=1).
- After flush at edge f with ce held high, q_valid[c] stays 0 until the word captured at edge f+1 reaches tap k. That word is the first valid one.
- ce gaps stretch latency in wall-clock terms but not in ce-qualified cycles.
- Maximum delay k = MXSR−1 (15 at defaults). No wrap-around; delay has no out-of-range values.

## Structure
- Shared package/include holds:
  - the derived MXSR expression
  - channel slice macros for d, delay and q indexing
- Sub-module x_delay_ch: one channel (WIDTH, MXDLY, OREG). It contains the stages, valid bits, the mux and the optional output register.
- Top x_delay_nch: a generate loop over NCH instances of x_delay_ch. It contains no logic of its own.

## Test plan
- Reset then fill: reset_n=0 for 3 clocks, then ce=1, d[ch0]=0x01,0x02,... on successive clocks, delay[ch0]=5, OREG=0.
  - q_valid[0]=0 for 4 edges.
  - Then q[0]=0x01 with q_valid=1.
  - q tracks d delayed 5 thereafter.
- Independent channels: delays 0/3/7/15 on ch0..3 with a counting pattern.
  - Each q[c] equals d from k_c clocks earlier.
  - ch0 equals the current d.
- ce gating: ce low for 4 clocks mid-stream.
  - Outputs hold.
  - Delay counted in ce cycles is unchanged.
  - No words are lost or duplicated.
- Flush while ce=1 at delay 4: q_valid drops the edge after flush and returns 4 edges after the following shift. Data never corrupted.
- Delay change 2→9 live:
  - q switches to sr[9] the same cycle.
  - q_valid=1 only if 9 stages have filled since the last reset or flush.
- OREG=1 regression of scenarios 1–2: every latency +1, and q=0/q_valid=0 during reset.
